// File: rtl/div_iter_unit_pkg.sv
// rtl/div_iter_unit_pkg.sv - shared constants and FSM encoding for the iterative divider
package div_iter_unit_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int CNT_W     = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    // Quotient returned for a zero divisor; there is no trap path.
    localparam logic [DIV_WIDTH-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/div_iter_unit_div_step.sv
// rtl/div_iter_unit_div_step.sv - one combinational radix-2 restoring division step
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic [1:0]       unused_bits;

    assign shifted = {rem_in, quo_in[WIDTH-1]};
    assign diff    = {1'b0, shifted} - {2'b00, divisor};

    // Top bits only matter for a zero divisor, where the remainder must wrap back to the dividend.
    assign unused_bits = {diff[WIDTH], shifted[WIDTH]};

    always_comb begin
        rem_out = shifted[WIDTH-1:0];
        quo_out = {quo_in[WIDTH-2:0], 1'b0};
        if (!diff[WIDTH+1]) begin
            rem_out = diff[WIDTH-1:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_iter_unit.sv
// rtl/div_iter_unit.sv - iterative signed/unsigned divider with FSM, sign fixup and stall handshake
module div_iter_unit
    import div_iter_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       stall,
    input  logic             flush,
    input  logic             div_en,
    input  logic             sign_flag,
    input  logic             rem_flag,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stallreq_for_div,
    output logic [WIDTH-1:0] result,
    output logic             result_valid
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             div0_q, div0_d;
    logic             rem_sel_q, rem_sel_d;

    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH-1:0] step_rem, step_quo;
    logic [WIDTH-1:0] quo_fix, rem_fix;
    logic             last_step;
    logic [4:0]       unused_stall;

    assign unused_stall = {stall[5:3], stall[1:0]};

    // Magnitudes fit WIDTH bits unsigned, including the most negative dividend.
    assign abs_a = (sign_flag && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign abs_b = (sign_flag && b[WIDTH-1]) ? (~b + 1'b1) : b;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (dvsr_q),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    assign last_step = (cnt_q == CNT_W'(WIDTH - 1));
    assign quo_fix   = div0_q    ? WIDTH'(DIV0_QUOT)
                     : neg_quo_q ? (~step_quo + 1'b1) : step_quo;
    assign rem_fix   = neg_rem_q ? (~step_rem + 1'b1) : step_rem;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        result_d  = result_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        rem_sel_d = rem_sel_q;
        case (state_q)
            ST_IDLE: begin
                if (div_en && !flush) begin
                    state_d   = ST_BUSY;
                    cnt_d     = '0;
                    rem_d     = '0;
                    quo_d     = abs_a;
                    dvsr_d    = abs_b;
                    neg_quo_d = sign_flag && (a[WIDTH-1] != b[WIDTH-1]);
                    neg_rem_d = sign_flag && a[WIDTH-1];
                    div0_d    = (b == '0);
                    rem_sel_d = rem_flag;
                end
            end
            ST_BUSY: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 1'b1;
                if (last_step) begin
                    state_d  = ST_DONE;
                    result_d = rem_sel_q ? rem_fix : quo_fix;
                end
            end
            ST_DONE: begin
                if (!stall[2]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A flush abandons any operation; the result register keeps its old value.
        if (flush) begin
            state_d  = ST_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            result_q  <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            rem_sel_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            result_q  <= result_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            rem_sel_q <= rem_sel_d;
        end
    end

    // The start cycle stalls combinationally so the operand lock holds a and b from cycle 0.
    assign stallreq_for_div = (state_q == ST_BUSY) ||
                              ((state_q == ST_IDLE) && div_en && !flush && !reset);
    assign result_valid     = (state_q == ST_DONE);
    assign result           = result_q;

endmodule
